// File: rtl/regfile_port_sched.sv
// Write-port arbiter and read-gating scheduler for a 32x32 2R1W register file.
// ALU/LSU writebacks share the write port round-robin; reads stall on same-register writes.
module regfile_port_sched #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_rs1,
  input  logic [ADDR_W-1:0] rd_rs2,
  output logic              rd_data_valid,
  output logic              rf_read_en,
  output logic [ADDR_W-1:0] rf_rs1_addr,
  output logic [ADDR_W-1:0] rf_rs2_addr,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic              dvalid_q, dvalid_d;
  logic              hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_LSU;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      ren_q        <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      dvalid_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      ren_q        <= ren_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      dvalid_q     <= dvalid_d;
    end
  end

  // Under contention the requester that did not win last time gets the port.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst) begin
      if (alu_valid && lsu_valid) begin
        alu_ready = (last_grant_q == GRANT_LSU);
        lsu_ready = (last_grant_q == GRANT_ALU);
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // A handshake to r0 still rotates priority but never issues a write.
  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    if (alu_valid && alu_ready) begin
      last_grant_d = GRANT_ALU;
      if (!(ZERO_REG != 0 && alu_addr == '0)) begin
        wen_d   = 1'b1;
        waddr_d = alu_addr;
        wdata_d = alu_data;
      end
    end else if (lsu_valid && lsu_ready) begin
      last_grant_d = GRANT_LSU;
      if (!(ZERO_REG != 0 && lsu_addr == '0)) begin
        wen_d   = 1'b1;
        waddr_d = lsu_addr;
        wdata_d = lsu_data;
      end
    end
  end

  assign hazard   = wen_q && (waddr_q != '0) && ((waddr_q == rd_rs1) || (waddr_q == rd_rs2));
  assign rd_ready = rst && rd_valid && !hazard;

  always_comb begin
    ren_d    = rd_ready;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    dvalid_d = ren_q;
    if (rd_ready) begin
      rs1_d = rd_rs1;
      rs2_d = rd_rs2;
    end
  end

  assign rf_write_en   = wen_q;
  assign rf_write_addr = waddr_q;
  assign rf_write_data = wdata_q;
  assign rf_read_en    = ren_q;
  assign rf_rs1_addr   = rs1_q;
  assign rf_rs2_addr   = rs2_q;
  assign rd_data_valid = dvalid_q;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched: reference model plus write/read scoreboards.
module tb_regfile_port_sched;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0, lsu_valid = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0, lsu_addr = '0, rd_rs1 = '0, rd_rs2 = '0;
  logic [DW-1:0] alu_data = '0, lsu_data = '0;
  logic          alu_ready, lsu_ready, rd_ready, rd_data_valid, rf_read_en, rf_write_en;
  logic [AW-1:0] rf_rs1_addr, rf_rs2_addr, rf_write_addr;
  logic [DW-1:0] rf_write_data;

  regfile_port_sched #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .rd_data_valid(rd_data_valid), .rf_read_en(rf_read_en),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic [AW-1:0] r1; logic [AW-1:0] r2; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int checks = 0;
  int failures = 0;
  // Reference model state: m_last=1 means the LSU won the last handshake.
  logic          m_last = 1'b1, m_wen = 1'b0, m_ren = 1'b0, m_dv = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic          o_alu, o_lsu, o_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1; m_wen = 1'b0; m_ren = 1'b0; m_dv = 1'b0; m_waddr = '0;
    wq.delete();
    rq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"}, rf_write_en, 0);
    chk({tag, "_waddr"}, rf_write_addr, 0);
    chk({tag, "_wdata"}, rf_write_data, 0);
    chk({tag, "_ren"}, rf_read_en, 0);
    chk({tag, "_rs"}, {rf_rs1_addr, rf_rs2_addr}, 0);
    chk({tag, "_dv"}, rd_data_valid, 0);
    chk({tag, "_readies"}, {alu_ready, lsu_ready, rd_ready}, 0);
  endtask

  // Checks handshakes of the current cycle, advances one clock, checks issued outputs.
  task automatic cycle();
    logic ea, el, er, hz, nwen;
    wr_t  w;
    rd_t  r;
    #2;
    if (alu_valid && lsu_valid) begin
      ea = m_last; el = !m_last;
    end else begin
      ea = alu_valid; el = lsu_valid;
    end
    hz = m_wen && (m_waddr != 0) && ((m_waddr == rd_rs1) || (m_waddr == rd_rs2));
    er = rd_valid && !hz;
    o_alu = alu_ready; o_lsu = lsu_ready; o_rd = rd_ready;
    chk("alu_ready", alu_ready, ea);
    chk("lsu_ready", lsu_ready, el);
    chk("rd_ready", rd_ready, er);
    chk("single_grant", alu_ready && lsu_ready, 0);
    nwen = 1'b0;
    if (ea) begin
      m_last = 1'b0;
      if (alu_addr != 0) begin nwen = 1'b1; m_waddr = alu_addr; wq.push_back({alu_addr, alu_data}); end
    end else if (el) begin
      m_last = 1'b1;
      if (lsu_addr != 0) begin nwen = 1'b1; m_waddr = lsu_addr; wq.push_back({lsu_addr, lsu_data}); end
    end
    if (er) rq.push_back({rd_rs1, rd_rs2});
    @(posedge clk);
    #1;
    m_dv = m_ren; m_ren = er; m_wen = nwen;
    chk("rf_write_en", rf_write_en, m_wen);
    if (m_wen) begin
      if (wq.size() == 0) chk("wq_empty", 1, 0);
      else begin
        w = wq.pop_front();
        chk("rf_write_addr", rf_write_addr, w.a);
        chk("rf_write_data", rf_write_data, w.d);
      end
    end
    chk("rf_read_en", rf_read_en, m_ren);
    if (m_ren) begin
      if (rq.size() == 0) chk("rq_empty", 1, 0);
      else begin
        r = rq.pop_front();
        chk("rf_rs1_addr", rf_rs1_addr, r.r1);
        chk("rf_rs2_addr", rf_rs2_addr, r.r2);
      end
    end
    chk("rd_data_valid", rd_data_valid, m_dv);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int exp_rr[4] = '{3, 7, 3, 7};

  initial begin
    alu_valid = 1'b1; lsu_valid = 1'b1; rd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0; rd_valid = 1'b0;

    // Single ALU write.
    alu_valid = 1'b1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("t1_alu_ready", o_alu, 1);
    chk("t1_waddr", rf_write_addr, 5);
    chk("t1_wdata", rf_write_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    cycle();

    // Contention alternates starting with the ALU.
    do_reset("t2_reset");
    alu_valid = 1'b1; alu_addr = 3; alu_data = 32'hA0A0_0003;
    lsu_valid = 1'b1; lsu_addr = 7; lsu_data = 32'h5050_0007;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_alu_grant", o_alu, (i % 2) == 0);
      chk("t2_rr_addr", rf_write_addr, exp_rr[i]);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cycle();

    // Write to r0 handshakes without issuing.
    lsu_valid = 1'b1; lsu_addr = 0; lsu_data = 32'h12345678;
    cycle();
    chk("t3_lsu_ready", o_lsu, 1);
    chk("t3_no_wen", rf_write_en, 0);
    alu_valid = 1'b1; alu_addr = 3; lsu_addr = 7;
    cycle();
    chk("t3_alu_wins", o_alu, 1);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cycle();

    // Read-after-write hazard stalls one cycle.
    alu_valid = 1'b1; alu_addr = 9; alu_data = 32'h0000_0909;
    cycle();
    alu_valid = 1'b0;
    rd_valid = 1'b1; rd_rs1 = 9; rd_rs2 = 2;
    cycle();
    chk("t4_stall", o_rd, 0);
    cycle();
    chk("t4_accept", o_rd, 1);
    rd_valid = 1'b0;
    chk("t4_ren", rf_read_en, 1);
    chk("t4_rs1", rf_rs1_addr, 9);
    cycle();
    chk("t4_dv", rd_data_valid, 1);
    cycle();

    // Unrelated read and write proceed together.
    alu_valid = 1'b1; alu_addr = 10; alu_data = 32'hCAFE_0010;
    cycle();
    alu_valid = 1'b0;
    rd_valid = 1'b1; rd_rs1 = 4; rd_rs2 = 6;
    chk("t5_wen10", rf_write_en && (rf_write_addr == 10), 1);
    cycle();
    chk("t5_rd_ready", o_rd, 1);
    chk("t5_addrs", {rf_read_en, rf_rs1_addr, rf_rs2_addr}, {1'b1, 5'd4, 5'd6});
    rd_valid = 1'b0;
    cycle();
    cycle();

    // Reset mid-stream with both requesters valid.
    alu_valid = 1'b1; alu_addr = 11; alu_data = 32'h1111_0011;
    lsu_valid = 1'b1; lsu_addr = 12; lsu_data = 32'h2222_0012;
    rd_valid = 1'b1; rd_rs1 = 1; rd_rs2 = 2;
    cycle();
    cycle();
    do_reset("t6_reset");
    rd_valid = 1'b0;
    cycle();
    chk("t6_alu_first", o_alu, 1);
    chk("t6_addr", rf_write_addr, 11);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
